// File: rtl/mtl_layer_compositor_avalon.sv
// MTL LCD controller: parametrised video timing, N rectangle layers composited over a
// background colour, shadowed layer/enable registers committed at frame start, Avalon-MM CSRs.
module mtl_layer_compositor_avalon #(
  parameter int N_LAYERS = 4,
  parameter int H_LINE   = 1056,
  parameter int V_LINE   = 525,
  parameter int H_BLANK  = 46,
  parameter int H_FP     = 210,
  parameter int V_BLANK  = 23,
  parameter int V_FP     = 22,
  parameter int HSYNC_W  = 1,
  parameter int VSYNC_W  = 1
) (
  input  logic        Avalon_CLK_50,
  input  logic        iRST_n,
  input  logic [7:0]  Avalon_address,
  input  logic        Avalon_read,
  output logic [31:0] Avalon_readdata,
  input  logic        Avalon_write,
  input  logic [31:0] Avalon_writedata,
  input  logic        iPIX_EN,
  output logic        oIRQ,
  output logic        oNewFrame,
  output logic        oEndFrame,
  output logic        oHD,
  output logic        oVD,
  output logic [7:0]  oLCD_R,
  output logic [7:0]  oLCD_G,
  output logic [7:0]  oLCD_B
);

  localparam logic [10:0] X_LAST    = 11'(H_LINE - 1);
  localparam logic [9:0]  Y_LAST    = 10'(V_LINE - 1);
  localparam logic [10:0] X_ACT_LO  = 11'(H_BLANK);
  localparam logic [10:0] X_ACT_HI  = 11'(H_LINE - H_FP);
  localparam logic [10:0] X_ACT_END = 11'(H_LINE - H_FP - 1);
  localparam logic [9:0]  Y_ACT_LO  = 10'(V_BLANK);
  localparam logic [9:0]  Y_ACT_HI  = 10'(V_LINE - V_FP);
  localparam logic [9:0]  Y_ACT_END = 10'(V_LINE - V_FP - 1);
  localparam logic [10:0] X_HS      = 11'(HSYNC_W);
  localparam logic [9:0]  Y_VS      = 10'(VSYNC_W);
  localparam logic [7:0]  LAYER_BASE = 8'd4;

  function automatic logic [31:0] layer_word(input logic [1:0] sub, input logic [10:0] x0,
                                             input logic [9:0] y0, input logic [10:0] x1,
                                             input logic [9:0] y1, input logic [23:0] rgb,
                                             input logic en);
    case (sub)
      2'd0:    layer_word = {6'd0, y0, 5'd0, x0};
      2'd1:    layer_word = {6'd0, y1, 5'd0, x1};
      2'd2:    layer_word = {7'd0, en, rgb};
      default: layer_word = 32'd0;
    endcase
  endfunction

  function automatic logic layer_hit(input logic [10:0] px, input logic [9:0] py,
                                     input logic [10:0] x0, input logic [10:0] x1,
                                     input logic [9:0] y0, input logic [9:0] y1,
                                     input logic en);
    layer_hit = en && (px >= x0) && (px <= x1) && (py >= y0) && (py <= y1);
  endfunction

  logic [10:0] x_cnt_q, x_cnt_d;
  logic [9:0]  y_cnt_q, y_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        vblank_q, vblank_d;
  logic        en_sh_q, en_sh_d, en_lv_q, en_lv_d;
  logic        irq_en_q, irq_en_d, irq_pend_q, irq_pend_d, irq_out_q, irq_out_d;
  logic        commit_pend_q, commit_pend_d;
  logic [23:0] bg_q, bg_d;
  logic [31:0] rdata_q, rdata_d;
  logic [23:0] colour_q, colour_d;
  logic        hd_q, hd_d, vd_q, vd_d;

  logic [N_LAYERS-1:0][10:0] sh_x0_q, sh_x0_d, sh_x1_q, sh_x1_d, lv_x0_q, lv_x0_d, lv_x1_q, lv_x1_d;
  logic [N_LAYERS-1:0][9:0]  sh_y0_q, sh_y0_d, sh_y1_q, sh_y1_d, lv_y0_q, lv_y0_d, lv_y1_q, lv_y1_d;
  logic [N_LAYERS-1:0][23:0] sh_rgb_q, sh_rgb_d, lv_rgb_q, lv_rgb_d;
  logic [N_LAYERS-1:0]       sh_en_q, sh_en_d, lv_en_q, lv_en_d;

  logic        new_frame_s, end_frame_s, vact_start_s, commit_now_s, active_s;
  logic [10:0] px_s;
  logic [9:0]  py_s;
  logic [23:0] top_s;
  logic [7:0]  lay_off_s;
  logic [5:0]  lay_idx_s;
  logic [1:0]  lay_sub_s;
  logic        lay_sel_s, ctrl_we_s, ack_s, bg_we_s;
  logic [N_LAYERS-1:0] we_xy0_s, we_xy1_s, we_col_s;
  logic [31:0] lay_rd_s, rd_s;
  logic        unused_wd_s;

  assign new_frame_s  = iPIX_EN && (x_cnt_q == 11'd0) && (y_cnt_q == 10'd0);
  assign end_frame_s  = iPIX_EN && (x_cnt_q == X_ACT_END) && (y_cnt_q == Y_ACT_END);
  assign vact_start_s = iPIX_EN && (x_cnt_q == 11'd0) && (y_cnt_q == Y_ACT_LO);
  assign commit_now_s = new_frame_s && commit_pend_q;
  assign active_s     = (x_cnt_q >= X_ACT_LO) && (x_cnt_q < X_ACT_HI) &&
                        (y_cnt_q >= Y_ACT_LO) && (y_cnt_q < Y_ACT_HI);
  assign px_s         = x_cnt_q - X_ACT_LO;
  assign py_s         = y_cnt_q - Y_ACT_LO;

  // Layer n occupies word addresses 4+4n .. 4+4n+3; the fourth word is reserved.
  assign lay_off_s   = Avalon_address - LAYER_BASE;
  assign lay_idx_s   = lay_off_s[7:2];
  assign lay_sub_s   = lay_off_s[1:0];
  assign lay_sel_s   = (Avalon_address >= LAYER_BASE);
  assign ctrl_we_s   = Avalon_write && (Avalon_address == 8'd0);
  assign ack_s       = Avalon_write && (Avalon_address == 8'd2) && Avalon_writedata[0];
  assign bg_we_s     = Avalon_write && (Avalon_address == 8'd3);
  assign unused_wd_s = ^Avalon_writedata[31:26];

  // Per-layer write strobes and shadow readback word.
  always_comb begin
    we_xy0_s = '0;
    we_xy1_s = '0;
    we_col_s = '0;
    lay_rd_s = 32'd0;
    for (int n = 0; n < N_LAYERS; n++) begin
      we_xy0_s[n] = Avalon_write && lay_sel_s && (lay_idx_s == 6'(n)) && (lay_sub_s == 2'd0);
      we_xy1_s[n] = Avalon_write && lay_sel_s && (lay_idx_s == 6'(n)) && (lay_sub_s == 2'd1);
      we_col_s[n] = Avalon_write && lay_sel_s && (lay_idx_s == 6'(n)) && (lay_sub_s == 2'd2);
      lay_rd_s = (lay_sel_s && (lay_idx_s == 6'(n))) ?
                 layer_word(lay_sub_s, sh_x0_q[n], sh_y0_q[n], sh_x1_q[n], sh_y1_q[n],
                            sh_rgb_q[n], sh_en_q[n]) : lay_rd_s;
    end
  end

  // CSR read mux; values are taken before any same-cycle write lands.
  always_comb begin
    rd_s = 32'd0;
    case (Avalon_address)
      8'd0:    rd_s = {29'd0, commit_pend_q, irq_en_q, en_sh_q};
      8'd1:    rd_s = {13'd0, irq_pend_q, commit_pend_q, vblank_q, frame_cnt_q};
      8'd2:    rd_s = 32'd0;
      8'd3:    rd_s = {8'd0, bg_q};
      default: rd_s = lay_rd_s;
    endcase
  end

  // Highest-index hitting layer wins over the background.
  always_comb begin
    top_s = bg_q;
    for (int n = 0; n < N_LAYERS; n++) begin
      top_s = layer_hit(px_s, py_s, lv_x0_q[n], lv_x1_q[n], lv_y0_q[n], lv_y1_q[n], lv_en_q[n]) ?
              lv_rgb_q[n] : top_s;
    end
  end

  // Raster counters and frame status.
  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (iPIX_EN) begin
      if (x_cnt_q == X_LAST) begin
        x_cnt_d = 11'd0;
        y_cnt_d = (y_cnt_q == Y_LAST) ? 10'd0 : y_cnt_q + 10'd1;
      end else begin
        x_cnt_d = x_cnt_q + 11'd1;
      end
    end else begin
      x_cnt_d = x_cnt_q;
    end
    frame_cnt_d = new_frame_s ? frame_cnt_q + 16'd1 : frame_cnt_q;
    if (end_frame_s) begin
      vblank_d = 1'b1;
    end else if (vact_start_s) begin
      vblank_d = 1'b0;
    end else begin
      vblank_d = vblank_q;
    end
  end

  // Control, interrupt and shadow/live register updates.
  always_comb begin
    commit_pend_d = (ctrl_we_s && Avalon_writedata[2]) ? 1'b1 :
                    (commit_now_s ? 1'b0 : commit_pend_q);
    en_sh_d    = ctrl_we_s ? Avalon_writedata[0] : en_sh_q;
    irq_en_d   = ctrl_we_s ? Avalon_writedata[1] : irq_en_q;
    en_lv_d    = commit_now_s ? en_sh_q : en_lv_q;
    bg_d       = bg_we_s ? Avalon_writedata[23:0] : bg_q;
    irq_pend_d = end_frame_s ? 1'b1 : (ack_s ? 1'b0 : irq_pend_q);
    irq_out_d  = irq_pend_d & irq_en_d;
    rdata_d    = Avalon_read ? rd_s : rdata_q;
    lv_x0_d    = commit_now_s ? sh_x0_q  : lv_x0_q;
    lv_y0_d    = commit_now_s ? sh_y0_q  : lv_y0_q;
    lv_x1_d    = commit_now_s ? sh_x1_q  : lv_x1_q;
    lv_y1_d    = commit_now_s ? sh_y1_q  : lv_y1_q;
    lv_rgb_d   = commit_now_s ? sh_rgb_q : lv_rgb_q;
    lv_en_d    = commit_now_s ? sh_en_q  : lv_en_q;
    sh_x0_d    = sh_x0_q;
    sh_y0_d    = sh_y0_q;
    sh_x1_d    = sh_x1_q;
    sh_y1_d    = sh_y1_q;
    sh_rgb_d   = sh_rgb_q;
    sh_en_d    = sh_en_q;
    for (int n = 0; n < N_LAYERS; n++) begin
      sh_x0_d[n]  = we_xy0_s[n] ? Avalon_writedata[10:0]  : sh_x0_q[n];
      sh_y0_d[n]  = we_xy0_s[n] ? Avalon_writedata[25:16] : sh_y0_q[n];
      sh_x1_d[n]  = we_xy1_s[n] ? Avalon_writedata[10:0]  : sh_x1_q[n];
      sh_y1_d[n]  = we_xy1_s[n] ? Avalon_writedata[25:16] : sh_y1_q[n];
      sh_rgb_d[n] = we_col_s[n] ? Avalon_writedata[23:0]  : sh_rgb_q[n];
      sh_en_d[n]  = we_col_s[n] ? Avalon_writedata[24]    : sh_en_q[n];
    end
  end

  // Pixel output stage, one pixel behind the counters.
  always_comb begin
    colour_d = colour_q;
    hd_d     = hd_q;
    vd_d     = vd_q;
    if (iPIX_EN) begin
      hd_d     = (x_cnt_q >= X_HS);
      vd_d     = (y_cnt_q >= Y_VS);
      colour_d = !active_s ? 24'd0 : (en_lv_q ? top_s : bg_q);
    end else begin
      colour_d = colour_q;
    end
  end

  // State registers.
  always_ff @(posedge Avalon_CLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      x_cnt_q       <= 11'd0;
      y_cnt_q       <= 10'd0;
      frame_cnt_q   <= 16'd0;
      vblank_q      <= 1'b0;
      en_sh_q       <= 1'b0;
      en_lv_q       <= 1'b0;
      irq_en_q      <= 1'b0;
      irq_pend_q    <= 1'b0;
      irq_out_q     <= 1'b0;
      commit_pend_q <= 1'b0;
      bg_q          <= 24'd0;
      rdata_q       <= 32'd0;
      colour_q      <= 24'd0;
      hd_q          <= 1'b1;
      vd_q          <= 1'b1;
      sh_x0_q <= '0; sh_y0_q <= '0; sh_x1_q <= '0; sh_y1_q <= '0; sh_rgb_q <= '0; sh_en_q <= '0;
      lv_x0_q <= '0; lv_y0_q <= '0; lv_x1_q <= '0; lv_y1_q <= '0; lv_rgb_q <= '0; lv_en_q <= '0;
    end else begin
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      vblank_q      <= vblank_d;
      en_sh_q       <= en_sh_d;
      en_lv_q       <= en_lv_d;
      irq_en_q      <= irq_en_d;
      irq_pend_q    <= irq_pend_d;
      irq_out_q     <= irq_out_d;
      commit_pend_q <= commit_pend_d;
      bg_q          <= bg_d;
      rdata_q       <= rdata_d;
      colour_q      <= colour_d;
      hd_q          <= hd_d;
      vd_q          <= vd_d;
      sh_x0_q <= sh_x0_d; sh_y0_q <= sh_y0_d; sh_x1_q <= sh_x1_d; sh_y1_q <= sh_y1_d;
      sh_rgb_q <= sh_rgb_d; sh_en_q <= sh_en_d;
      lv_x0_q <= lv_x0_d; lv_y0_q <= lv_y0_d; lv_x1_q <= lv_x1_d; lv_y1_q <= lv_y1_d;
      lv_rgb_q <= lv_rgb_d; lv_en_q <= lv_en_d;
    end
  end

  assign Avalon_readdata = rdata_q;
  assign oIRQ            = irq_out_q;
  assign oNewFrame       = new_frame_s;
  assign oEndFrame       = end_frame_s;
  assign oHD             = hd_q;
  assign oVD             = vd_q;
  assign oLCD_R          = colour_q[23:16];
  assign oLCD_G          = colour_q[15:8];
  assign oLCD_B          = colour_q[7:0];

endmodule

// File: tb/tb_mtl_layer_compositor_avalon.sv
// Bench for mtl_layer_compositor_avalon: small raster, integer pixel-index reference model,
// directed scenarios with literal expectations, then randomized CSR traffic.
module tb_mtl_layer_compositor_avalon;
  localparam int NL = 3, H = 20, V = 10, HB = 4, HFP = 4, VB = 2, VFP = 2, HSW = 1, VSW = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] addr;
  logic rd, wr, pix_en;
  logic [31:0] wdata, rdata;
  logic irq, nf, ef, hd, vd;
  logic [7:0] r, g, b;

  always #5 clk = ~clk;

  mtl_layer_compositor_avalon #(
    .N_LAYERS(NL), .H_LINE(H), .V_LINE(V), .H_BLANK(HB), .H_FP(HFP),
    .V_BLANK(VB), .V_FP(VFP), .HSYNC_W(HSW), .VSYNC_W(VSW)
  ) dut (
    .Avalon_CLK_50(clk), .iRST_n(rst_n), .Avalon_address(addr), .Avalon_read(rd),
    .Avalon_readdata(rdata), .Avalon_write(wr), .Avalon_writedata(wdata), .iPIX_EN(pix_en),
    .oIRQ(irq), .oNewFrame(nf), .oEndFrame(ef), .oHD(hd), .oVD(vd),
    .oLCD_R(r), .oLCD_G(g), .oLCD_B(b)
  );

  int n_chk = 0, n_pass = 0, mode = 0;

  // Reference model: pixel index p = y*H + x, plus the register file as plain arrays.
  int m_p, m_frame;
  bit m_en_sh, m_en_lv, m_irq_en, m_commit, m_irqp, m_vbl, m_oirq, m_hd, m_vd;
  logic [23:0] m_bg, m_col;
  logic [31:0] m_rdata;
  int sh_x0[NL], sh_y0[NL], sh_x1[NL], sh_y1[NL], lv_x0[NL], lv_y0[NL], lv_x1[NL], lv_y1[NL];
  logic [23:0] sh_rgb[NL], lv_rgb[NL];
  bit sh_en[NL], lv_en[NL];

  function automatic void m_reset();
    m_p = 0; m_frame = 0; m_en_sh = 0; m_en_lv = 0; m_irq_en = 0; m_commit = 0; m_irqp = 0;
    m_vbl = 0; m_oirq = 0; m_hd = 1; m_vd = 1; m_bg = 0; m_col = 0; m_rdata = 0;
    for (int k = 0; k < NL; k++) begin
      sh_x0[k] = 0; sh_y0[k] = 0; sh_x1[k] = 0; sh_y1[k] = 0; sh_rgb[k] = 0; sh_en[k] = 0;
      lv_x0[k] = 0; lv_y0[k] = 0; lv_x1[k] = 0; lv_y1[k] = 0; lv_rgb[k] = 0; lv_en[k] = 0;
    end
  endfunction

  function automatic logic [31:0] m_read(int a);
    int n, s;
    if (a == 0) return {29'd0, m_commit, m_irq_en, m_en_sh};
    if (a == 1) return {13'd0, m_irqp, m_commit, m_vbl, 16'(m_frame)};
    if (a == 3) return {8'd0, m_bg};
    if (a < 4) return 32'd0;
    n = (a - 4) / 4; s = (a - 4) % 4;
    if (n >= NL) return 32'd0;
    if (s == 0) return 32'(sh_y0[n] * 65536 + sh_x0[n]);
    if (s == 1) return 32'(sh_y1[n] * 65536 + sh_x1[n]);
    if (s == 2) return {7'd0, sh_en[n], sh_rgb[n]};
    return 32'd0;
  endfunction

  function automatic void m_step();
    int x, y, px, py, a, n, s;
    bit nfe, efe;
    logic [23:0] top;
    x = m_p % H; y = m_p / H;
    if (rd) m_rdata = m_read(int'(addr));
    if (pix_en) begin
      px = x - HB; py = y - VB;
      top = m_bg;
      for (int k = 0; k < NL; k++)
        if (lv_en[k] && px >= lv_x0[k] && px <= lv_x1[k] && py >= lv_y0[k] && py <= lv_y1[k])
          top = lv_rgb[k];
      if (!(x >= HB && x < H - HFP && y >= VB && y < V - VFP)) m_col = 24'd0;
      else m_col = m_en_lv ? top : m_bg;
      m_hd = (x >= HSW); m_vd = (y >= VSW);
    end
    nfe = pix_en && m_p == 0;
    efe = pix_en && x == H - HFP - 1 && y == V - VFP - 1;
    if (nfe) m_frame = (m_frame + 1) % 65536;
    if (pix_en && x == 0 && y == VB) m_vbl = 0;
    if (efe) m_vbl = 1;
    if (nfe && m_commit) begin
      lv_x0 = sh_x0; lv_y0 = sh_y0; lv_x1 = sh_x1; lv_y1 = sh_y1; lv_rgb = sh_rgb; lv_en = sh_en;
      m_en_lv = m_en_sh; m_commit = 0;
    end
    if (wr) begin
      a = int'(addr);
      if (a == 0) begin
        m_en_sh = wdata[0]; m_irq_en = wdata[1];
        if (wdata[2]) m_commit = 1;
      end else if (a == 2) begin
        if (wdata[0]) m_irqp = 0;
      end else if (a == 3) begin
        m_bg = wdata[23:0];
      end else if (a >= 4) begin
        n = (a - 4) / 4; s = (a - 4) % 4;
        if (n < NL) begin
          if (s == 0) begin sh_x0[n] = int'(wdata[10:0]); sh_y0[n] = int'(wdata[25:16]); end
          if (s == 1) begin sh_x1[n] = int'(wdata[10:0]); sh_y1[n] = int'(wdata[25:16]); end
          if (s == 2) begin sh_rgb[n] = wdata[23:0]; sh_en[n] = wdata[24]; end
        end
      end
    end
    if (efe) m_irqp = 1;
    m_oirq = m_irqp && m_irq_en;
    if (pix_en) m_p = (m_p + 1) % (H * V);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: event not seen within cycle budget", nm);
  endtask

  // One clock: compare every output with the model at the falling edge, then set next inputs.
  task automatic tick();
    @(negedge clk);
    chk("colour", {8'd0, r, g, b}, {8'd0, m_col});
    chk("hsync", hd, m_hd);
    chk("vsync", vd, m_vd);
    chk("newframe", nf, pix_en && (m_p == 0));
    chk("endframe", ef, pix_en && (m_p == (V - VFP - 1) * H + (H - HFP - 1)));
    chk("irq", irq, m_oirq);
    chk("readdata", rdata, m_rdata);
    rd = 1'b0; wr = 1'b0;
    case (mode)
      0: pix_en = 1'b1;
      1: pix_en = ~pix_en;
      default: pix_en = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic av_write(input int a, input logic [31:0] d);
    addr = 8'(a); wdata = d; wr = 1'b1; tick();
  endtask

  task automatic av_read(input int a);
    addr = 8'(a); rd = 1'b1; tick();
  endtask

  task automatic wait_nf(output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (nf !== 1'b1 && cyc < 1000);
    if (cyc >= 1000) timeout("wait_newframe");
  endtask

  task automatic wait_ef(output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (ef !== 1'b1 && cyc < 1000);
    if (cyc >= 1000) timeout("wait_endframe");
  endtask

  // Stop once the output stage shows active pixel (px,py); needs iPIX_EN held high.
  task automatic wait_pix(input int px, input int py);
    int cyc, tgt;
    cyc = 0; tgt = (py + VB) * H + px + HB + 1;
    while (m_p != tgt && cyc < 1000) begin tick(); cyc++; end
    if (cyc >= 1000) timeout("wait_pixel");
  endtask

  initial begin
    int cyc, lo_h, lo_v, k, a;
    logic [31:0] d;
    rst_n = 1'b0; addr = 8'd0; rd = 1'b0; wr = 1'b0; wdata = 32'd0; pix_en = 1'b1;
    tick(); tick();
    chk("rst_hd", hd, 1'b1); chk("rst_vd", vd, 1'b1);
    chk("rst_colour", {8'd0, r, g, b}, 32'd0); chk("rst_irq", irq, 1'b0);
    chk("rst_readdata", rdata, 32'd0);
    rst_n = 1'b1;

    // Frame timing on the small raster.
    wait_nf(cyc); wait_nf(cyc); chk("frame_period", cyc, 200);
    wait_ef(cyc); chk("endframe_offset", cyc, 155);
    lo_h = 0; lo_v = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (hd === 1'b0) lo_h++;
      if (vd === 1'b0) lo_v++;
    end
    chk("hsync_low_count", lo_h, 10); chk("vsync_low_count", lo_v, 20);

    // Two overlapping layers over a background, committed together.
    av_write(3, 32'h0010_2030);
    av_write(4, {6'd0, 10'd1, 5'd0, 11'd2}); av_write(5, {6'd0, 10'd3, 5'd0, 11'd5});
    av_write(6, 32'h01FF_0000);
    av_write(8, {6'd0, 10'd2, 5'd0, 11'd4}); av_write(9, {6'd0, 10'd4, 5'd0, 11'd8});
    av_write(10, 32'h0100_FF00);
    av_write(0, 32'h7);
    av_read(0); chk("ctrl_commit_pending", rdata, 32'h7);
    wait_nf(cyc);
    wait_pix(3, 1); chk("red_pixel", {8'd0, r, g, b}, 32'h00FF_0000);
    wait_pix(4, 2); chk("green_pixel", {8'd0, r, g, b}, 32'h0000_FF00);
    wait_pix(9, 5); chk("bg_pixel", {8'd0, r, g, b}, 32'h0010_2030);

    // Shadow write without commit stays invisible until committed.
    av_write(6, 32'h0100_00FF);
    av_read(6); chk("l0col_readback", rdata, 32'h0100_00FF);
    wait_nf(cyc); wait_pix(3, 1); chk("uncommitted_red", {8'd0, r, g, b}, 32'h00FF_0000);
    av_write(0, 32'h7);
    wait_nf(cyc); wait_pix(3, 1); chk("committed_blue", {8'd0, r, g, b}, 32'h0000_00FF);

    // Interrupt set, acknowledge, and acknowledge colliding with the set.
    av_write(2, 32'h1); chk("irq_acked", irq, 1'b0);
    wait_ef(cyc); tick(); chk("irq_after_endframe", irq, 1'b1);
    av_write(2, 32'h1); chk("irq_cleared", irq, 1'b0);
    wait_ef(cyc);
    addr = 8'd2; wdata = 32'h1; wr = 1'b1; tick();
    chk("irq_set_beats_ack", irq, 1'b1);

    // Half-rate pixel enable doubles the frame period.
    mode = 1;
    wait_nf(cyc); wait_nf(cyc); chk("frame_period_half_rate", cyc, 400);

    // Asynchronous reset in the middle of a frame.
    mode = 0;
    wait_nf(cyc); wait_pix(5, 1);
    av_read(1);
    rst_n = 1'b0; #1;
    chk("midrst_hd", hd, 1'b1); chk("midrst_vd", vd, 1'b1);
    chk("midrst_colour", {8'd0, r, g, b}, 32'd0); chk("midrst_irq", irq, 1'b0);
    chk("midrst_readdata", rdata, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    av_read(1); chk("status_after_reset", rdata, 32'd0);

    // Randomized CSR traffic with a random pixel enable.
    mode = 2;
    for (int i = 0; i < 4000; i++) begin
      k = $urandom_range(0, 9);
      if (k < 4) begin
        a = $urandom_range(0, 4 + 4 * NL + 4);
        if ($urandom_range(0, 30) == 0) a = 255;
        d = $urandom;
        if (a >= 4 && a < 4 + 4 * NL && ((a - 4) % 4) < 2) begin
          d[10:0] = 11'($urandom_range(0, 13));
          d[25:16] = 10'($urandom_range(0, 7));
        end
        if (a == 0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
        addr = 8'(a); wdata = d; wr = 1'b1;
        if (k == 3) rd = 1'b1;
      end else if (k < 6) begin
        addr = 8'($urandom_range(0, 4 + 4 * NL + 4)); rd = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
